// File: rtl/shake_port_arbiter_pkg.sv
// shake_port_arbiter_pkg: shared constants and FSM state type for the SHAKE port arbiter
package shake_port_arbiter_pkg;
  localparam int SHAKE_DATA_W = 32;
  localparam int REQ_ERR = 0;
  localparam int REQ_C1 = 1;
  localparam int REQ_K = 2;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD, FLUSH} arb_state_t;
endpackage

// File: rtl/shake_port_arbiter_if.sv
// shake_port_arbiter_if: requester-side and core-side handshake bundle of the SHAKE port arbiter
interface shake_port_arbiter_if import shake_port_arbiter_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = SHAKE_DATA_W
);
  logic [NUM_REQ-1:0] req_i, rel_i, gnt_o;
  logic [NUM_REQ-1:0] r_din_valid_i, r_din_ready_o, r_dout_valid_o, r_dout_ready_i, r_force_done_i;
  logic [NUM_REQ*DATA_W-1:0] r_din_i;
  logic [DATA_W-1:0] r_dout_o, s_din_o, s_dout_i;
  logic s_din_valid_o, s_din_ready_i, s_dout_valid_i, s_dout_ready_o, s_force_done_o, busy_o;
  modport master (
    output req_i, rel_i, r_din_valid_i, r_din_i, r_dout_ready_i, r_force_done_i,
    output s_din_ready_i, s_dout_valid_i, s_dout_i,
    input gnt_o, r_din_ready_o, r_dout_valid_o, r_dout_o,
    input s_din_valid_o, s_din_o, s_dout_ready_o, s_force_done_o, busy_o
  );
  modport slave (
    input req_i, rel_i, r_din_valid_i, r_din_i, r_dout_ready_i, r_force_done_i,
    input s_din_ready_i, s_dout_valid_i, s_dout_i,
    output gnt_o, r_din_ready_o, r_dout_valid_o, r_dout_o,
    output s_din_valid_o, s_din_o, s_dout_ready_o, s_force_done_o, busy_o
  );
endinterface

// File: rtl/shake_port_arbiter_rr_pick.sv
// shake_port_arbiter_rr_pick: picks the first set request at or after ptr_i, wrapping around
module shake_port_arbiter_rr_pick #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic [IDX_W:0] j;
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, ptr_i} + (IDX_W+1)'(k);
      j = j >= (IDX_W+1)'(NUM_REQ) ? j - (IDX_W+1)'(NUM_REQ) : j;
      if (!found && req_i[j[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = j[IDX_W-1:0];
      end
    end
    gnt_o[idx_o] = found;
  end
endmodule

// File: rtl/shake_port_arbiter.sv
// shake_port_arbiter: round-robin, grant-locked sharing of one SHAKE core among NUM_REQ requesters
module shake_port_arbiter import shake_port_arbiter_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = SHAKE_DATA_W,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  shake_port_arbiter_if.slave bus
);
  arb_state_t state_q;
  logic [NUM_REQ-1:0] gnt_q, pick_gnt;
  logic [IDX_W-1:0] own_q, rr_q, pick_idx;
  logic [DATA_W-1:0] din_arr [NUM_REQ];
  logic hold;
  shake_port_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i(bus.req_i),
    .ptr_i(rr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_din
    assign din_arr[i] = bus.r_din_i[i*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      own_q <= '0;
      rr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|bus.req_i) begin
          gnt_q <= pick_gnt;
          own_q <= pick_idx;
          state_q <= GRANT;
        end
        GRANT: state_q <= HOLD;
        HOLD: if (bus.rel_i[own_q] || !bus.req_i[own_q]) state_q <= FLUSH;
        default: begin
          gnt_q <= '0;
          rr_q <= own_q == IDX_W'(NUM_REQ-1) ? '0 : own_q + 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  // Only the owner reaches the core, and only once the settle cycle is over
  assign hold = state_q == HOLD;
  assign bus.gnt_o = gnt_q;
  assign bus.busy_o = state_q == GRANT || hold;
  assign bus.s_din_valid_o = hold && bus.r_din_valid_i[own_q];
  assign bus.s_din_o = hold ? din_arr[own_q] : '0;
  assign bus.s_dout_ready_o = hold && bus.r_dout_ready_i[own_q];
  assign bus.s_force_done_o = state_q == FLUSH || (hold && bus.r_force_done_i[own_q]);
  assign bus.r_din_ready_o = hold && bus.s_din_ready_i ? gnt_q : '0;
  assign bus.r_dout_valid_o = hold && bus.s_dout_valid_i ? gnt_q : '0;
  assign bus.r_dout_o = bus.s_dout_i;
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
endmodule

// File: tb/tb_shake_port_arbiter.sv
// tb_shake_port_arbiter: directed stimulus checked against an owner/phase model of the arbiter
module tb_shake_port_arbiter;
  localparam int N = 3;
  localparam int W = 32;
  typedef logic [76:0] outs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit en = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int m_own = -1;
  int m_ptr = 0;
  bit m_open = 1'b0;
  bit m_flush = 1'b0;
  shake_port_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  shake_port_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int rr_first(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // Model: who owns the core, whether the settle cycle has passed, whether a flush is due
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_own <= -1;
      m_ptr <= 0;
      m_open <= 1'b0;
      m_flush <= 1'b0;
    end else if (m_flush) begin
      m_ptr <= (m_own + 1) % N;
      m_own <= -1;
      m_flush <= 1'b0;
      m_open <= 1'b0;
    end else if (m_own >= 0) begin
      if (m_open && (bus.rel_i[m_own] || !bus.req_i[m_own])) m_flush <= 1'b1;
      m_open <= 1'b1;
    end else if (bus.req_i != '0) m_own <= rr_first(bus.req_i, m_ptr);
  function automatic outs_t expected();
    logic pass;
    logic [N-1:0] oh;
    oh = m_own >= 0 ? N'(1 << m_own) : '0;
    pass = m_own >= 0 && m_open && !m_flush;
    return {oh, m_own >= 0 && !m_flush, pass && bus.r_din_valid_i[m_own],
            pass ? bus.r_din_i[m_own*W +: W] : W'(0), pass && bus.r_dout_ready_i[m_own],
            m_flush || (pass && bus.r_force_done_i[m_own]),
            pass && bus.s_din_ready_i ? oh : N'(0), pass && bus.s_dout_valid_i ? oh : N'(0), bus.s_dout_i};
  endfunction
  always @(negedge clk) if (en) begin
    outs_t act, exp_o;
    act = {bus.gnt_o, bus.busy_o, bus.s_din_valid_o, bus.s_din_o, bus.s_dout_ready_o, bus.s_force_done_o,
           bus.r_din_ready_o, bus.r_dout_valid_o, bus.r_dout_o};
    exp_o = expected();
    vectors++;
    if (act !== exp_o) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act, exp_o);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic look();
    @(negedge clk);
  endtask
  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 12 && g == '0; c++) begin
      @(negedge clk);
      g = bus.gnt_o;
    end
  endtask
  task automatic set_din(input int idx, input logic [W-1:0] v);
    bus.r_din_i[idx*W +: W] = v;
  endtask
  initial begin
    logic [N-1:0] g;
    logic [N-1:0] exp_order [4];
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    bus.req_i = '0;
    bus.rel_i = '0;
    bus.r_din_valid_i = '0;
    bus.r_din_i = '0;
    bus.r_dout_ready_i = '0;
    bus.r_force_done_i = '0;
    bus.s_din_ready_i = 1'b0;
    bus.s_dout_valid_i = 1'b0;
    bus.s_dout_i = '0;
    #1 rst = 1'b0;
    tick();
    tick();
    en = 1'b1;
    look();
    chk("reset_gnt", 32'(bus.gnt_o), 0);
    chk("reset_busy", 32'(bus.busy_o), 0);
    chk("reset_fd", 32'(bus.s_force_done_o), 0);
    tick();
    rst = 1'b1;
    tick();
    bus.req_i = 3'b001;
    bus.s_din_ready_i = 1'b1;
    bus.r_din_valid_i = 3'b001;
    set_din(0, 32'hA0);
    look();
    chk("single_idle_gnt", 32'(bus.gnt_o), 0);
    tick();
    look();
    chk("single_gnt", 32'(bus.gnt_o), 32'b001);
    chk("single_settle", 32'(bus.s_din_valid_o), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_din(0, 32'hA0 + 32'(i));
      look();
      chk("single_din", bus.s_din_o, 32'hA0 + 32'(i));
      chk("single_rdy", 32'(bus.r_din_ready_o), 32'b001);
      tick();
    end
    bus.r_din_valid_i = '0;
    bus.rel_i = 3'b001;
    look();
    chk("single_fd_pre", 32'(bus.s_force_done_o), 0);
    tick();
    bus.rel_i = '0;
    bus.req_i = '0;
    look();
    chk("single_flush", 32'(bus.s_force_done_o), 1);
    tick();
    look();
    chk("single_fd_post", 32'(bus.s_force_done_o), 0);
    chk("single_gnt_off", 32'(bus.gnt_o), 0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      chk("rr_order", 32'(g), 32'(exp_order[k]));
      tick();
      bus.rel_i = g;
      tick();
      bus.rel_i = '0;
      if (k == 3) bus.req_i = '0;
      tick();
    end
    bus.req_i = 3'b100;
    wait_gnt(g);
    chk("gate_gnt", 32'(g), 32'b100);
    tick();
    bus.s_dout_valid_i = 1'b1;
    bus.s_dout_i = 32'hDEADBEEF;
    bus.r_dout_ready_i = 3'b111;
    bus.r_din_valid_i = 3'b011;
    look();
    chk("gate_dout_valid", 32'(bus.r_dout_valid_o), 32'b100);
    chk("gate_dout_ready", 32'(bus.s_dout_ready_o), 1);
    chk("gate_din_valid", 32'(bus.s_din_valid_o), 0);
    chk("gate_dout", bus.r_dout_o, 32'hDEADBEEF);
    tick();
    bus.rel_i = 3'b001;
    bus.r_force_done_i = 3'b001;
    look();
    chk("gate_nonowner_fd", 32'(bus.s_force_done_o), 0);
    tick();
    bus.rel_i = '0;
    bus.r_force_done_i = '0;
    look();
    chk("gate_hold_kept", 32'(bus.gnt_o), 32'b100);
    chk("gate_busy", 32'(bus.busy_o), 1);
    tick();
    bus.rel_i = 3'b100;
    bus.r_force_done_i = 3'b100;
    look();
    chk("gate_relfd", 32'(bus.s_force_done_o), 1);
    tick();
    bus.rel_i = '0;
    bus.r_force_done_i = '0;
    bus.req_i = '0;
    bus.s_dout_valid_i = 1'b0;
    bus.r_din_valid_i = '0;
    bus.r_dout_ready_i = '0;
    look();
    chk("gate_flush", 32'(bus.s_force_done_o), 1);
    tick();
    bus.req_i = 3'b010;
    wait_gnt(g);
    chk("abandon_gnt", 32'(g), 32'b010);
    tick();
    bus.req_i = 3'b110;
    tick();
    bus.req_i = 3'b100;
    look();
    chk("abandon_busy", 32'(bus.busy_o), 1);
    tick();
    look();
    chk("abandon_flush", 32'(bus.s_force_done_o), 1);
    tick();
    look();
    chk("abandon_idle", 32'(bus.gnt_o), 0);
    tick();
    look();
    chk("abandon_next", 32'(bus.gnt_o), 32'b100);
    tick();
    bus.rel_i = 3'b100;
    tick();
    bus.rel_i = '0;
    bus.req_i = '0;
    tick();
    bus.req_i = 3'b001;
    wait_gnt(g);
    chk("b2b_gnt", 32'(g), 32'b001);
    tick();
    bus.rel_i = 3'b001;
    tick();
    bus.rel_i = '0;
    look();
    chk("b2b_flush", 32'(bus.gnt_o), 32'b001);
    tick();
    look();
    chk("b2b_idle", 32'(bus.gnt_o), 0);
    tick();
    look();
    chk("b2b_regrant", 32'(bus.gnt_o), 32'b001);
    tick();
    bus.rel_i = 3'b001;
    bus.req_i = '0;
    tick();
    bus.rel_i = '0;
    tick();
    bus.req_i = 3'b010;
    wait_gnt(g);
    chk("rst_gnt", 32'(g), 32'b010);
    tick();
    bus.r_din_valid_i = 3'b010;
    bus.r_force_done_i = 3'b010;
    look();
    chk("rst_pre_dv", 32'(bus.s_din_valid_o), 1);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(bus.gnt_o), 0);
    chk("rst_mid_dv", 32'(bus.s_din_valid_o), 0);
    chk("rst_mid_fd", 32'(bus.s_force_done_o), 0);
    tick();
    rst = 1'b1;
    look();
    chk("rst_idle_busy", 32'(bus.busy_o), 0);
    chk("rst_idle_gnt", 32'(bus.gnt_o), 0);
    tick();
    bus.req_i = '0;
    bus.r_din_valid_i = '0;
    bus.r_force_done_i = '0;
    tick();
    tick();
    tick();
    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
